sync_fifo_thresh: RTL and testbench
===================================

// Module: sync_fifo_thresh
// PURPOSE
//  Single-clock, parametrised FIFO for controller command/data queues: power-of-2 depth, fill count,
//  programmable almost-full/almost-empty flags, sticky overflow/underflow, synchronous flush.
//  Read mode is selectable: show-ahead (first-word-fall-through) or registered 1-cycle read.
// PARAMETERS
//  WIDTH      8   data word width, bits
//  ADDR_W     6   log2(depth); DEPTH = 2**ADDR_W entries, all usable
//  FWFT       1   1: data_out shows head word combinationally; 0: registered read, 1-cycle latency
//  AF_THRESH  56  almost_full asserted when fillcount >= AF_THRESH (1..DEPTH)
//  AE_THRESH  8   almost_empty asserted when fillcount <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1         rising-edge clock
//  reset         in   1         synchronous, active-high reset
//  data_in       in   WIDTH     write data, sampled when put accepted
//  put           in   1         write request
//  get           in   1         read request
//  flush         in   1         synchronous discard of all contents
//  err_clr       in   1         clears overflow/underflow
//  data_out      out  WIDTH     read data (see BEHAVIOUR)
//  rd_valid      out  1         FWFT=0 only: data_out valid this cycle; tied to !empty when FWFT=1
//  empty         out  1         fillcount == 0
//  full          out  1         fillcount == DEPTH
//  almost_empty  out  1         fillcount <= AE_THRESH
//  almost_full   out  1         fillcount >= AF_THRESH
//  fillcount     out  ADDR_W+1  entries held, 0..DEPTH
//  overflow      out  1         sticky: put while full
//  underflow     out  1         sticky: get while empty
// BEHAVIOUR
//  - Reset (sync, priority over all): wr_ptr=rd_ptr=0, fillcount=0, empty=1, full=0, almost_empty=1,
//    almost_full=0, overflow=underflow=0, rd_valid=0, registered data_out=0. Memory not cleared.
//  - put_acc = put & !full; get_acc = get & !empty. Gating uses flags at clock edge; no write-through
//    when full, no read-through when empty, even with the opposite request in the same cycle.
//  - put_acc: mem[wr_ptr]<=data_in, wr_ptr+1. get_acc: rd_ptr+1. Pointers ADDR_W bits, wrap mod DEPTH.
//  - fillcount: +1 if put_acc only, -1 if get_acc only, unchanged if both or neither. Never exceeds DEPTH.
//  - All flags decoded combinationally from registered fillcount; no flag glitch on wrap.
//  - FWFT=1: data_out = mem[rd_ptr] combinational; valid whenever !empty; get_acc advances to next word.
//  - FWFT=0: on get_acc, data_out <= mem[rd_ptr] and rd_valid<=1 next cycle; else rd_valid<=0,
//    data_out holds last value. Read latency exactly 1 clk.
//  - overflow<=1 on put & full; underflow<=1 on get & empty; hold until err_clr or reset.
//    err_clr and new error in same cycle: error wins (flag stays 1).
//  - flush (below reset, above put/get): pointers=0, fillcount=0, rd_valid<=0; put/get that cycle
//    ignored and do not set error flags. Sticky flags unaffected by flush.
//  - Reset/flush mid-stream: all in-flight entries lost; first put afterward lands at address 0.
// STRUCTURE
//  - Shared include fifo_defs.vh: read-mode constants FWFT_SHOWAHEAD=1, FWFT_REGISTERED=0.
//  - Sub-module sdp_ram (WIDTH, ADDR_W): 1 write port (clk, we, waddr, wdata), async read port.
//    FWFT=0 adds the output register in sync_fifo_thresh, not in sdp_ram.
//  - Elaboration check: AF_THRESH in 1..DEPTH, AE_THRESH < DEPTH; otherwise $error.
// TESTING  (WIDTH=8, ADDR_W=3 -> DEPTH=8, AF_THRESH=6, AE_THRESH=1)
//  1 Reset then 8 puts 0x10..0x17 -> fillcount 8, full=1, almost_full from 6th put; 9th put 0xFF
//    -> rejected, overflow=1, fillcount stays 8.
//  2 FWFT=1: drain 8 gets -> data_out 0x10..0x17 in order, empty=1 after 8th; extra get -> underflow=1.
//  3 FWFT=0: put 0xA5, get next cycle -> rd_valid=1 and data_out=0xA5 one cycle after get, rd_valid=0 after.
//  4 Fill to 8, then put+get same cycle -> put rejected, get accepted, fillcount 7; at fillcount 4 put+get
//    together for 20 cycles -> fillcount stays 4, pointers wrap, data order preserved.
//  5 fillcount 5, assert flush with put+get -> fillcount 0, empty=1, no error flags; next put 0x3C
//    read back as 0x3C.
//  6 overflow=1 then err_clr -> 0; err_clr with put while full same cycle -> overflow stays 1;
//    reset mid-fill (fillcount 3) -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/sync_fifo_thresh_pkg.sv
// Package for sync_fifo_thresh: fill-count update encoding and its decode.
package sync_fifo_thresh_pkg;

    typedef enum logic [1:0] {
        FILL_HOLD = 2'd0,
        FILL_INC  = 2'd1,
        FILL_DEC  = 2'd2
    } fill_op_e;

    // Simultaneous accepted put and get leave the count unchanged.
    function automatic fill_op_e fill_op(input logic put_acc, input logic get_acc);
        fill_op_e op;
        op = FILL_HOLD;
        if (put_acc && !get_acc) op = FILL_INC;
        if (get_acc && !put_acc) op = FILL_DEC;
        return op;
    endfunction

endpackage

// File: rtl/fifo_defs.vh
// Shared read-mode constants for the FIFO family.
//   FWFT_SHOWAHEAD  : head word presented combinationally on data_out
//   FWFT_REGISTERED : data_out registered, one clock after an accepted get
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FWFT_SHOWAHEAD  1
`define FWFT_REGISTERED 0

`endif

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Contents are not initialised or cleared by any reset.
// Ports:
//   clk    in  write clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from raddr)
module sdp_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with fill count, programmable almost-full/almost-empty,
// sticky overflow/underflow and synchronous flush. Read mode selected by FWFT.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   data_in, put            write data / write request
//   get                     read request
//   flush                   discard all contents (below reset, above put/get)
//   err_clr                 clear sticky error flags (a new error the same cycle wins)
//   data_out, rd_valid      read data and its valid
//   empty, full             fillcount == 0 / == DEPTH
//   almost_empty/full       fillcount <= AE_THRESH / >= AF_THRESH
//   fillcount               entries held, 0..DEPTH
//   overflow, underflow     sticky: put while full / get while empty
`include "fifo_defs.vh"

module sync_fifo_thresh
    import sync_fifo_thresh_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 6,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              put,
    input  logic              get,
    input  logic              flush,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   fillcount,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_thresh
        $error("sync_fifo_thresh: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
    end

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   fill_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic [WIDTH-1:0]  ram_rdata;
    logic              put_acc;
    logic              get_acc;

    // Flags decode only the registered count, so they cannot glitch on pointer wrap.
    assign empty        = (fill_reg == '0);
    assign full         = (fill_reg == DEPTH_C);
    assign almost_empty = (fill_reg <= AE_C);
    assign almost_full  = (fill_reg >= AF_C);
    assign fillcount    = fill_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // Acceptance uses this cycle's flags only: no write-through when full,
    // no read-through when empty. A flush swallows both requests.
    assign put_acc = put && !full  && !flush;
    assign get_acc = get && !empty && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (put_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (get_acc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case (fill_op(put_acc, get_acc))
                FILL_INC: fill_reg <= fill_reg + 1'b1;
                FILL_DEC: fill_reg <= fill_reg - 1'b1;
                default:  fill_reg <= fill_reg;
            endcase
        end
    end

    // Sticky errors: setting has priority over err_clr; flush neither sets nor clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (put && full && !flush) overflow_reg <= 1'b1;
            else if (err_clr)          overflow_reg <= 1'b0;
            if (get && empty && !flush) underflow_reg <= 1'b1;
            else if (err_clr)           underflow_reg <= 1'b0;
        end
    end

    sdp_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (put_acc),
        .waddr (wr_ptr_reg),
        .wdata (data_in),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    if (FWFT == `FWFT_SHOWAHEAD) begin : g_showahead
        assign data_out = ram_rdata;
        assign rd_valid = !empty;
    end else begin : g_registered
        logic [WIDTH-1:0] dout_reg;
        logic             rd_valid_reg;

        // Valid pulses for exactly the cycle after an accepted get; data holds otherwise.
        always_ff @(posedge clk) begin
            if (reset) begin
                dout_reg     <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= get_acc;
                if (get_acc) dout_reg <= ram_rdata;
            end
        end

        assign data_out = dout_reg;
        assign rd_valid = rd_valid_reg;
    end

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench: DEPTH=8, AF_THRESH=6, AE_THRESH=1. Two instances share the
// stimulus, one show-ahead and one registered-read.
module tb_sync_fifo_thresh;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             put;
    logic             get;
    logic             flush;
    logic             err_clr;

    logic [WIDTH-1:0] dout_sa, dout_rg;
    logic             rdv_sa, rdv_rg;
    logic             empty_sa, empty_rg, full_sa, full_rg;
    logic             ae_sa, ae_rg, af_sa, af_rg;
    logic [ADDR_W:0]  fill_sa, fill_rg;
    logic             ovf_sa, ovf_rg, unf_sa, unf_rg;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] model_q[$];

    sync_fifo_thresh #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)
    ) u_dut_sa (
        .clk(clk), .reset(reset), .data_in(data_in), .put(put), .get(get),
        .flush(flush), .err_clr(err_clr), .data_out(dout_sa), .rd_valid(rdv_sa),
        .empty(empty_sa), .full(full_sa), .almost_empty(ae_sa), .almost_full(af_sa),
        .fillcount(fill_sa), .overflow(ovf_sa), .underflow(unf_sa)
    );

    sync_fifo_thresh #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)
    ) u_dut_rg (
        .clk(clk), .reset(reset), .data_in(data_in), .put(put), .get(get),
        .flush(flush), .err_clr(err_clr), .data_out(dout_rg), .rd_valid(rdv_rg),
        .empty(empty_rg), .full(full_rg), .almost_empty(ae_rg), .almost_full(af_rg),
        .fillcount(fill_rg), .overflow(ovf_rg), .underflow(unf_rg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic e_empty, input logic e_full,
                               input logic e_ae, input logic e_af);
        check_val({tag, ".empty_sa"}, 32'(empty_sa), 32'(e_empty));
        check_val({tag, ".empty_rg"}, 32'(empty_rg), 32'(e_empty));
        check_val({tag, ".full_sa"},  32'(full_sa),  32'(e_full));
        check_val({tag, ".full_rg"},  32'(full_rg),  32'(e_full));
        check_val({tag, ".ae_sa"},    32'(ae_sa),    32'(e_ae));
        check_val({tag, ".af_sa"},    32'(af_sa),    32'(e_af));
        check_val({tag, ".af_rg"},    32'(af_rg),    32'(e_af));
    endtask

    task automatic check_errs(input string tag, input logic e_ovf, input logic e_unf);
        check_val({tag, ".ovf_sa"}, 32'(ovf_sa), 32'(e_ovf));
        check_val({tag, ".ovf_rg"}, 32'(ovf_rg), 32'(e_ovf));
        check_val({tag, ".unf_sa"}, 32'(unf_sa), 32'(e_unf));
        check_val({tag, ".unf_rg"}, 32'(unf_rg), 32'(e_unf));
    endtask

    // One clock of stimulus against the queue model: head/data and count are checked.
    task automatic xfer(input string tag, input logic p, input logic g, input logic f,
                        input logic ec, input logic [WIDTH-1:0] d);
        logic             pa, ga;
        logic [WIDTH-1:0] popped;
        pa = p && !f && (model_q.size() < DEPTH);
        ga = g && !f && (model_q.size() > 0);
        popped = '0;
        if (ga) begin
            popped = model_q[0];
            check_val({tag, ".head_sa"}, 32'(dout_sa), 32'(popped));
            check_val({tag, ".rdv_sa"},  32'(rdv_sa),  32'd1);
        end
        put = p; get = g; flush = f; err_clr = ec; data_in = d;
        @(posedge clk);
        #1;
        put = 1'b0; get = 1'b0; flush = 1'b0; err_clr = 1'b0;
        if (f) begin
            model_q.delete();
        end else begin
            if (ga) void'(model_q.pop_front());
            if (pa) model_q.push_back(d);
        end
        $display("%s put=%b get=%b flush=%b din=%02h -> fill=%0d rdv_rg=%b dout_rg=%02h",
                 tag, p, g, f, d, fill_sa, rdv_rg, dout_rg);
        check_val({tag, ".fill_sa"}, 32'(fill_sa), 32'(model_q.size()));
        check_val({tag, ".fill_rg"}, 32'(fill_rg), 32'(model_q.size()));
        check_val({tag, ".rdv_rg"},  32'(rdv_rg),  32'(ga));
        if (ga) check_val({tag, ".dout_rg"}, 32'(dout_rg), 32'(popped));
    endtask

    task automatic do_reset(input logic p);
        reset = 1'b1; put = p; data_in = 8'h77;
        @(posedge clk);
        #1;
        reset = 1'b0; put = 1'b0;
        model_q.delete();
        $display("reset -> fill=%0d empty=%b", fill_sa, empty_sa);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".fill_sa"}, 32'(fill_sa), 32'd0);
        check_val({tag, ".fill_rg"}, 32'(fill_rg), 32'd0);
        check_flags(tag, 1'b1, 1'b0, 1'b1, 1'b0);
        check_errs(tag, 1'b0, 1'b0);
        check_val({tag, ".rdv_sa"},  32'(rdv_sa),  32'd0);
        check_val({tag, ".rdv_rg"},  32'(rdv_rg),  32'd0);
        check_val({tag, ".dout_rg"}, 32'(dout_rg), 32'd0);
    endtask

    initial begin
        reset = 1'b1; put = 1'b0; get = 1'b0; flush = 1'b0; err_clr = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);
        check_reset_state("rst");

        // 1: fill, almost_full from the 6th put, 9th put rejected
        for (int i = 0; i < DEPTH; i++) begin
            xfer($sformatf("t1.put%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
            check_val($sformatf("t1.af%0d", i), 32'(af_sa), 32'(i + 1 >= 6));
            check_val($sformatf("t1.ae%0d", i), 32'(ae_rg), 32'(i + 1 <= 1));
        end
        check_flags("t1.full", 1'b0, 1'b1, 1'b0, 1'b1);
        xfer("t1.put9", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        check_errs("t1.ovf", 1'b1, 1'b0);

        // 2: drain in order, then one get too many
        for (int i = 0; i < DEPTH; i++) begin
            check_val($sformatf("t2.exp%0d", i), 32'(dout_sa), 32'(8'h10 + i));
            xfer($sformatf("t2.get%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        check_flags("t2.empty", 1'b1, 1'b0, 1'b1, 1'b0);
        xfer("t2.get9", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_errs("t2.unf", 1'b1, 1'b1);
        check_val("t2.dout_hold", 32'(dout_rg), 32'h17);
        xfer("t2.clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_errs("t2.clr", 1'b0, 1'b0);

        // 3: registered read latency
        xfer("t3.put", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        check_val("t3.sa_show", 32'(dout_sa), 32'hA5);
        xfer("t3.get", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("t3.rg_data", 32'(dout_rg), 32'hA5);
        xfer("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_val("t3.rg_hold", 32'(dout_rg), 32'hA5);

        // 4: put+get while full, then put+get at fillcount 4 across pointer wrap
        for (int i = 0; i < DEPTH; i++)
            xfer($sformatf("t4.fill%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h20 + i));
        xfer("t4.pg_full", 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
        check_val("t4.fill7", 32'(fill_sa), 32'd7);
        check_errs("t4.ovf", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            xfer($sformatf("t4.dn%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 20; k++)
            xfer($sformatf("t4.pg%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + k));
        check_val("t4.fill4", 32'(fill_rg), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t4.tail%0d", i), 32'(dout_sa), 32'(8'h50 + i));
            xfer($sformatf("t4.drain%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end

        // 5: flush with put+get at fillcount 5
        xfer("t5.clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++)
            xfer($sformatf("t5.put%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
        xfer("t5.flush", 1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
        check_flags("t5.flush", 1'b1, 1'b0, 1'b1, 1'b0);
        check_errs("t5.flush", 1'b0, 1'b0);
        xfer("t5.put3c", 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
        check_val("t5.head3c", 32'(dout_sa), 32'h3C);
        xfer("t5.get3c", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("t5.rd3c", 32'(dout_rg), 32'h3C);

        // 6: err_clr, err_clr racing a new overflow, reset mid-fill
        for (int i = 0; i < DEPTH; i++)
            xfer($sformatf("t6.fill%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i));
        xfer("t6.ovf", 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        check_errs("t6.ovf", 1'b1, 1'b0);
        xfer("t6.clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_errs("t6.clr", 1'b0, 1'b0);
        xfer("t6.race", 1'b1, 1'b0, 1'b0, 1'b1, 8'hFE);
        check_errs("t6.race", 1'b1, 1'b0);
        xfer("t6.flush", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_errs("t6.flush_keep", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            xfer($sformatf("t6.put%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hC0 + i));
        xfer("t6.get", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("t6.fill3", 32'(fill_sa), 32'd3);
        do_reset(1'b1);
        check_reset_state("t6.rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
